// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   - state_t      : controller FSM states
//   - alu_op_t     : coarse ALU request from the FSM to alu_decoder
//   - ctl_t        : registered control word produced per state
//   - opcode/funct : instruction field encodings
//   - ALU_*        : ALU control codes (MC_ALU_W bits)
//   - *_SEL        : datapath mux select encodings
// ctl_of() maps a state to its Moore control word. funct_known() is only
// consulted when MC_TRAP_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL,
        S_JR, S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        AOP_NONE, AOP_ADD, AOP_SUB, AOP_FUNCT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam int MC_ALU_W = 5;
    localparam logic [MC_ALU_W-1:0] ALU_AND = 5'd0;
    localparam logic [MC_ALU_W-1:0] ALU_OR  = 5'd1;
    localparam logic [MC_ALU_W-1:0] ALU_ADD = 5'd2;
    localparam logic [MC_ALU_W-1:0] ALU_SUB = 5'd6;
    localparam logic [MC_ALU_W-1:0] ALU_SLT = 5'd7;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MEM    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] SRCB_RD2    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RD1    = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        alu_op_t    alu_op;
        logic       busy_wait;
    } ctl_t;

    // last = the memory wait counter has reached MEM_WAIT in this state
    function automatic ctl_t ctl_of(input state_t s, input logic last);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = AOP_ADD;
                c.pc_src    = PCSRC_ALU;
                c.ir_write  = last;
                c.pc_write  = last;
                c.busy_wait = !last;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = AOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = AOP_ADD;
            end
            S_MEMREAD: begin
                c.iord      = 1'b1;
                c.busy_wait = !last;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RT;
                c.mem_to_reg = M2R_MEM;
            end
            S_MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = last;
                c.busy_wait = !last;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = AOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RD;
                c.mem_to_reg = M2R_ALUOUT;
            end
            S_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RT;
                c.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = AOP_SUB;
                c.pc_src    = PCSRC_ALUOUT;
                c.branch    = 1'b1;
            end
            S_JUMP: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so it is the link value
                c.reg_write  = 1'b1;
                c.reg_dst    = REG_DST_RA;
                c.mem_to_reg = M2R_PC;
                c.pc_src     = PCSRC_JUMP;
                c.pc_write   = 1'b1;
            end
            S_JR: begin
                c.pc_src   = PCSRC_RD1;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic funct_known(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT) || (f == FN_JR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
//   master : controller side (takes opcode/funct/zero, drives controls)
//   slave  : datapath side
// trap exists only when MC_TRAP_EN is defined.
interface multicycle_controller_if #(
    parameter int ALU_CTRL_W = 5
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  pc_en;
    logic                  iord;
    logic                  ir_write;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            reg_dst;
    logic [1:0]            mem_to_reg;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  busy_wait;
`ifdef MC_TRAP_EN
    logic                  trap;
`endif

    modport master (
        input  opcode, funct, zero,
`ifdef MC_TRAP_EN
        output trap,
`endif
        output pc_en, iord, ir_write, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
               busy_wait
    );

    modport slave (
        output opcode, funct, zero,
`ifdef MC_TRAP_EN
        input  trap,
`endif
        input  pc_en, iord, ir_write, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
               busy_wait
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request plus the instruction funct field to the ALU
// control code. Unused funct codes fall back to AND (code 0).
//   alu_op      in  coarse request (none / add / sub / by funct)
//   funct       in  instr[5:0]
//   alu_control out ALU operation, ALU_CTRL_W bits
module alu_decoder
    import mc_pkg::*;
#(
    parameter int ALU_CTRL_W = 5
) (
    input  alu_op_t               alu_op,
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    logic [MC_ALU_W-1:0] code;

    always_comb begin
        code = ALU_AND;
        case (alu_op)
            AOP_ADD: code = ALU_ADD;
            AOP_SUB: code = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_AND;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle MIPS datapath.
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus (master)   : opcode/funct/zero in; all mux selects and enables out
// MEM_WAIT (0..15) stretches FETCH, MEMREAD and MEMWRITE by that many
// cycles; busy_wait flags the stalled cycles.
// Optional macro MC_TRAP_EN: unknown opcode / R-type funct parks the FSM in
// TRAP (trap=1, all enables low) until reset. Without it an unknown opcode
// behaves as a nop and an unknown funct executes as AND.
//
// state      | meaning
// IDLE       | in reset, all outputs low
// FETCH      | read instruction at PC, PC += 4 on last cycle
// DECODE     | branch target into ALUOut, dispatch on opcode
// MEMADR     | base + offset for lw/sw
// MEMREAD    | data read at ALUOut
// MEMWB      | memory data into rt
// MEMWRITE   | data write at ALUOut, strobe on last cycle
// EXECUTE    | R-type ALU op
// ALUWB      | ALUOut into rd
// ADDIEX     | rs + imm
// ADDIWB     | ALUOut into rt
// BRANCH     | compare, PC <- ALUOut when equal
// JUMP       | PC <- jump target
// JAL        | r31 <- PC, PC <- jump target
// JR         | PC <- rs
// TRAP       | illegal instruction, hold until reset
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEM_WAIT   = 0,
    parameter int ALU_CTRL_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    multicycle_controller_if.master bus
);

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

`ifdef MC_TRAP_EN
    localparam state_t UNKNOWN_NEXT = S_TRAP;
`else
    localparam state_t UNKNOWN_NEXT = S_FETCH;
`endif

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    ctl_t       ctl_q;
    logic       stalled;

    assign stalled = (wait_q != WAIT_MAX);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (stalled) wait_d = wait_q + 4'd1;
                else         state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode_sel(bus.opcode))
                    2'd1:    state_d = S_MEMADR;
                    2'd2: begin
                        if (bus.funct == FN_JR) state_d = S_JR;
`ifdef MC_TRAP_EN
                        else if (!funct_known(bus.funct)) state_d = S_TRAP;
`endif
                        else state_d = S_EXECUTE;
                    end
                    default: begin
                        case (bus.opcode)
                            OP_BEQ:  state_d = S_BRANCH;
                            OP_ADDI: state_d = S_ADDIEX;
                            OP_J:    state_d = S_JUMP;
                            OP_JAL:  state_d = S_JAL;
                            default: state_d = UNKNOWN_NEXT;
                        endcase
                    end
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (stalled) wait_d = wait_q + 4'd1;
                else         state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (stalled) wait_d = wait_q + 4'd1;
                else         state_d = S_FETCH;
            end
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                        state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
        // every state entry restarts the wait count; only the memory
        // states ever advance it
        if (state_d != state_q) wait_d = '0;
    end

    // 1 = lw/sw, 2 = R-type, 0 = everything else
    function automatic logic [1:0] opcode_sel(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) return 2'd1;
        if (op == OP_RTYPE)             return 2'd2;
        return 2'd0;
    endfunction

    // Outputs are registered from the next state, so they change in step
    // with state_q and come out of reset at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctl_q   <= ctl_of(state_d, wait_d == WAIT_MAX);
        end
    end

    alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .alu_op      (ctl_q.alu_op),
        .funct       (bus.funct),
        .alu_control (bus.alu_control)
    );

    assign bus.pc_en      = ctl_q.pc_write | (ctl_q.branch & bus.zero);
    assign bus.iord       = ctl_q.iord;
    assign bus.ir_write   = ctl_q.ir_write;
    assign bus.mem_write  = ctl_q.mem_write;
    assign bus.reg_write  = ctl_q.reg_write;
    assign bus.reg_dst    = ctl_q.reg_dst;
    assign bus.mem_to_reg = ctl_q.mem_to_reg;
    assign bus.alu_src_a  = ctl_q.alu_src_a;
    assign bus.alu_src_b  = ctl_q.alu_src_b;
    assign bus.pc_src     = ctl_q.pc_src;
    assign bus.busy_wait  = ctl_q.busy_wait;
`ifdef MC_TRAP_EN
    assign bus.trap       = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: one instance with MEM_WAIT=0 and one with
// MEM_WAIT=3, driven instruction by instruction and compared against an
// instruction-level model (latency, write strobes and their selects).
// The trap checks apply only when MC_TRAP_EN is defined.
module tb_multicycle_controller;

    localparam int W1 = 3;
    localparam logic [4:0] A_AND = 5'd0, A_OR = 5'd1, A_ADD = 5'd2,
                           A_SUB = 5'd6, A_SLT = 5'd7;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [4:0] alu_control;
        logic       busy_wait;
    } obs_t;

    typedef struct {
        int lat; int nmem; int rw; int dst; int m2r; int mw;
        int pe; int pe_src; int alu_ok; int alu; int pcs_ok; int pcs;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    multicycle_controller_if #(.ALU_CTRL_W(5)) bus0 ();
    multicycle_controller_if #(.ALU_CTRL_W(5)) bus1 ();

    multicycle_controller #(.MEM_WAIT(0), .ALU_CTRL_W(5)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0));
    multicycle_controller #(.MEM_WAIT(W1), .ALU_CTRL_W(5)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1));

    obs_t o0, o1;
    assign o0 = {bus0.pc_en, bus0.iord, bus0.ir_write, bus0.mem_write,
                 bus0.reg_write, bus0.reg_dst, bus0.mem_to_reg, bus0.alu_src_a,
                 bus0.alu_src_b, bus0.pc_src, bus0.alu_control, bus0.busy_wait};
    assign o1 = {bus1.pc_en, bus1.iord, bus1.ir_write, bus1.mem_write,
                 bus1.reg_write, bus1.reg_dst, bus1.mem_to_reg, bus1.alu_src_a,
                 bus1.alu_src_b, bus1.pc_src, bus1.alu_control, bus1.busy_wait};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [5:0] op, input logic [5:0] fn, input logic z);
        if (sel == 0) begin
            bus0.opcode = op; bus0.funct = fn; bus0.zero = z;
        end else begin
            bus1.opcode = op; bus1.funct = fn; bus1.zero = z;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    function automatic bit op_known(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                          6'b001000, 6'b000010, 6'b000011};
    endfunction

    function automatic bit fn_known(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b101010, 6'b001000};
    endfunction

    // Instruction-level expectations: cycle count, memory accesses that
    // stall, register/memory writes and PC updates.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int w);
        exp_t e;
        e = '{default: 0};
        e.nmem = 1; e.pe = 1; e.pe_src = 0;
        case (op)
            6'b100011: begin
                e.lat = 5 + 2*w; e.nmem = 2; e.rw = 1; e.dst = 0; e.m2r = 1;
                e.alu_ok = 1; e.alu = A_ADD;
            end
            6'b101011: begin
                e.lat = 4 + 2*w; e.nmem = 2; e.mw = 1; e.alu_ok = 1; e.alu = A_ADD;
            end
            6'b000000: begin
                if (fn == 6'b001000) begin
                    e.lat = 3 + w; e.pe = 2; e.pe_src = 3; e.pcs_ok = 1; e.pcs = 3;
                end else begin
                    e.lat = 4 + w; e.rw = 1; e.dst = 1; e.m2r = 0; e.alu_ok = 1;
                    case (fn)
                        6'b100000: e.alu = A_ADD;
                        6'b100010: e.alu = A_SUB;
                        6'b100100: e.alu = A_AND;
                        6'b100101: e.alu = A_OR;
                        6'b101010: e.alu = A_SLT;
                        default:   e.alu = A_AND;
                    endcase
                end
            end
            6'b000100: begin
                e.lat = 3 + w; e.alu_ok = 1; e.alu = A_SUB; e.pcs_ok = 1; e.pcs = 1;
                if (z) begin e.pe = 2; e.pe_src = 1; end
            end
            6'b001000: begin
                e.lat = 4 + w; e.rw = 1; e.dst = 0; e.m2r = 0; e.alu_ok = 1; e.alu = A_ADD;
            end
            6'b000010: begin
                e.lat = 3 + w; e.pe = 2; e.pe_src = 2; e.pcs_ok = 1; e.pcs = 2;
            end
            6'b000011: begin
                e.lat = 3 + w; e.rw = 1; e.dst = 2; e.m2r = 2;
                e.pe = 2; e.pe_src = 2; e.pcs_ok = 1; e.pcs = 2;
            end
            default: e.lat = 2 + w;
        endcase
        return e;
    endfunction

    // Called at the first cycle of FETCH; returns at the next one.
    // FETCH is recognised by alu_src_b == 1 (PC + 4), which no other state uses.
    task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input string nm);
        exp_t e;
        obs_t o, o3;
        int w, n, ir_cnt, ir_idx, busy, rw_cnt, rw_idx, rw_dst, rw_m2r;
        int mw_cnt, mw_idx, pe_cnt, pe_src;
        bit left, done;
        w = (sel == 0) ? 0 : W1;
        e = model(op, fn, z, w);
        drive(sel, op, fn, z);
        n = 0; ir_cnt = 0; ir_idx = 0; busy = 0; rw_cnt = 0; rw_idx = 0;
        rw_dst = 0; rw_m2r = 0; mw_cnt = 0; mw_idx = 0; pe_cnt = 0; pe_src = 0;
        left = 0; done = 0; o3 = '0;
        for (int k = 0; k < 80 && !done; k++) begin
            o = (sel == 0) ? o0 : o1;
            if (o.alu_src_b == 2'd1 && left) begin
                done = 1;
            end else begin
                n++;
                if (o.alu_src_b != 2'd1) left = 1;
                if (o.ir_write)  begin ir_cnt++; ir_idx = n; end
                if (o.busy_wait) busy++;
                if (o.reg_write) begin
                    rw_cnt++; rw_idx = n; rw_dst = o.reg_dst; rw_m2r = o.mem_to_reg;
                end
                if (o.mem_write) begin mw_cnt++; mw_idx = n; end
                if (o.pc_en)     begin pe_cnt++; pe_src = o.pc_src; end
                if (n == w + 3)  o3 = o;
                @(posedge clock);
                #1;
            end
        end
        chk({nm, ".done"}, done, 1);
        chk({nm, ".lat"}, n, e.lat);
        chk({nm, ".ir_cnt"}, ir_cnt, 1);
        chk({nm, ".ir_idx"}, ir_idx, w + 1);
        chk({nm, ".busy"}, busy, e.nmem * w);
        chk({nm, ".rw_cnt"}, rw_cnt, e.rw);
        if (e.rw != 0) begin
            chk({nm, ".rw_idx"}, rw_idx, e.lat);
            chk({nm, ".reg_dst"}, rw_dst, e.dst);
            chk({nm, ".mem_to_reg"}, rw_m2r, e.m2r);
        end
        chk({nm, ".mw_cnt"}, mw_cnt, e.mw);
        if (e.mw != 0) chk({nm, ".mw_idx"}, mw_idx, e.lat);
        chk({nm, ".pe_cnt"}, pe_cnt, e.pe);
        chk({nm, ".pe_src"}, pe_src, e.pe_src);
        if (e.alu_ok != 0) chk({nm, ".alu"}, o3.alu_control, e.alu);
        if (e.pcs_ok != 0) chk({nm, ".pc_src3"}, o3.pc_src, e.pcs);
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        case ($urandom_range(0, 11))
            0:       op = 6'b100011;
            1:       op = 6'b101011;
            2, 3, 4: op = 6'b000000;
            5:       op = 6'b000100;
            6:       op = 6'b001000;
            7:       op = 6'b000010;
            8:       op = 6'b000011;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return op;
    endfunction

    function automatic logic [5:0] rand_fn();
        logic [5:0] fn;
        case ($urandom_range(0, 6))
            0:       fn = 6'b100000;
            1:       fn = 6'b100010;
            2:       fn = 6'b100100;
            3:       fn = 6'b100101;
            4:       fn = 6'b101010;
            5:       fn = 6'b001000;
            default: fn = 6'($urandom_range(0, 63));
        endcase
        return fn;
    endfunction

    task automatic run_random(input int sel, input int count);
        logic [5:0] op, fn;
        logic z;
        for (int i = 0; i < count; i++) begin
            op = rand_op();
            fn = rand_fn();
            z  = 1'($urandom_range(0, 1));
`ifdef MC_TRAP_EN
            while (!op_known(op)) op = rand_op();
            while (!fn_known(fn)) fn = rand_fn();
`endif
            run_instr(sel, op, fn, z, $sformatf("rnd%0d_%0d_op%b_fn%b", sel, i, op, fn));
        end
    endtask

    initial begin
        drive(0, 6'd0, 6'd0, 1'b0);
        drive(1, 6'd0, 6'd0, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset.out0", o0, 0);
        chk("reset.out1", o1, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("release.ir0", o0.ir_write, 1);
        chk("release.pe0", o0.pc_en, 1);
        chk("release.ir1", o1.ir_write, 0);
        chk("release.busy1", o1.busy_wait, 1);

        run_instr(0, 6'b100011, 6'd0,      1'b0, "lw_w0");
        run_instr(0, 6'b000100, 6'd0,      1'b1, "beq_z1");
        run_instr(0, 6'b000100, 6'd0,      1'b0, "beq_z0");
        run_instr(0, 6'b000011, 6'd0,      1'b0, "jal");
        run_instr(0, 6'b000010, 6'd0,      1'b1, "j");
        run_instr(0, 6'b000000, 6'b001000, 1'b0, "jr");
        run_instr(0, 6'b000000, 6'b100010, 1'b0, "sub");
        run_instr(0, 6'b001000, 6'd0,      1'b0, "addi");
        run_instr(0, 6'b101011, 6'd0,      1'b0, "sw_w0");
`ifndef MC_TRAP_EN
        run_instr(0, 6'b000000, 6'b111111, 1'b0, "r_badfn");
        run_instr(0, 6'b111111, 6'd0,      1'b0, "bad_op");
`endif

        // reset asserted in the middle of EXECUTE, checked before any edge
        drive(0, 6'b000000, 6'b100000, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        chk("mid.exec_sel", {o0.alu_src_a, o0.alu_src_b}, 3'b100);
        reset_n = 1'b0;
        #1;
        chk("mid.reset_out", o0, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("mid.release_ir", o0.ir_write, 1);
        chk("mid.release_pe", o0.pc_en, 1);

        run_random(0, 30);

        do_reset();
        run_instr(1, 6'b101011, 6'd0, 1'b0, "sw_w3");
        run_instr(1, 6'b100011, 6'd0, 1'b0, "lw_w3");
        run_instr(1, 6'b000011, 6'd0, 1'b0, "jal_w3");
        run_random(1, 30);

`ifdef MC_TRAP_EN
        begin
            int good;
            do_reset();
            drive(0, 6'b111111, 6'd0, 1'b1);
            drive(1, 6'b000000, 6'b111111, 1'b1);
            repeat (2) @(posedge clock);
            #1;
            good = 0;
            for (int i = 0; i < 25; i++) begin
                if (bus0.trap === 1'b1 && o0.ir_write === 1'b0 && o0.reg_write === 1'b0 &&
                    o0.mem_write === 1'b0 && o0.pc_en === 1'b0)
                    good++;
                @(posedge clock);
                #1;
            end
            chk("trap.op_hold", good, 25);
            chk("trap.badfn", bus1.trap, 1);
            chk("trap.badfn_we", {o1.reg_write, o1.mem_write, o1.pc_en}, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
